regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 129 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Integer register file for the RV32 pipeline, with a busy-bit scoreboard
//   for RAW hazard detection at decode.
//   - Two combinational read ports (rs1/rs2) with write-first bypass from
//     the writeback port.
//   - One synchronous write port (write_en/rd_addr/rd_data); x0 reads 0 and
//     ignores writes.
//   - Scoreboard: issue_en/issue_rd sets a busy bit, writeback clears it,
//     flush clears all. rsN_busy flags a pending producer that is not
//     resolved by a same-cycle writeback. pending_count is the registered
//     popcount of the busy bits.
// Ports:
//   clk, rst               clock, async active-high reset
//   rs1_addr/data_out_rs1  read port 1
//   rs2_addr/data_out_rs2  read port 2
//   write_en/rd_addr/rd_data  writeback port
//   issue_en/issue_rd      issued destination register
//   flush                  squash all in-flight results
//   rs1_busy/rs2_busy      pending-write hazard per read port
//   pending_count          number of busy registers
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int ADDR = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ADDR-1:0] rs1_addr,
  output logic [XLEN-1:0] data_out_rs1,
  input  logic [ADDR-1:0] rs2_addr,
  output logic [XLEN-1:0] data_out_rs2,
  input  logic            write_en,
  input  logic [ADDR-1:0] rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            issue_en,
  input  logic [ADDR-1:0] issue_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [ADDR:0]   pending_count
);

  localparam int NREG = 1 << ADDR;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [ADDR:0]   count_q, count_d;

  logic wr_valid;
  assign wr_valid = write_en && (rd_addr != '0);

  // Storage next-state; x0 is held at zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_valid) begin
      regs_d[rd_addr] = rd_data;
    end
    regs_d[0] = '0;
  end

  // Scoreboard next-state. Issue beats a same-cycle writeback to the same
  // register since the newly issued producer is still outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (issue_en && (issue_rd == ADDR'(i))) begin
        busy_d[i] = 1'b1;
      end else if (write_en && (rd_addr == ADDR'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Count is computed from busy_d so it tracks busy_q on the same edge.
  always_comb begin
    count_d = '0;
    for (int i = 1; i < NREG; i++) begin
      count_d = count_d + {{ADDR{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Read ports with write-first bypass.
  always_comb begin
    if (rs1_addr == '0) begin
      data_out_rs1 = '0;
    end else if (write_en && (rd_addr == rs1_addr)) begin
      data_out_rs1 = rd_data;
    end else begin
      data_out_rs1 = regs_q[rs1_addr];
    end

    if (rs2_addr == '0) begin
      data_out_rs2 = '0;
    end else if (write_en && (rd_addr == rs2_addr)) begin
      data_out_rs2 = rd_data;
    end else begin
      data_out_rs2 = regs_q[rs2_addr];
    end
  end

  // A same-cycle writeback resolves the hazard through the bypass; busy_q[0]
  // is always 0 so address 0 never reports busy.
  assign rs1_busy = busy_q[rs1_addr] && !(write_en && (rd_addr == rs1_addr));
  assign rs2_busy = busy_q[rs2_addr] && !(write_en && (rd_addr == rs2_addr));

  assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Stimulus drives inputs shortly after
// each rising edge and queues the expected outputs for that cycle; a monitor
// samples the DUT on the falling edge and compares against the queue.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int ADDR = 5;

  localparam int S_RS1 = 0;
  localparam int S_RS2 = 1;
  localparam int S_B1  = 2;
  localparam int S_B2  = 3;
  localparam int S_CNT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [ADDR-1:0] rs1_addr, rs2_addr, rd_addr, issue_rd;
  logic [XLEN-1:0] data_out_rs1, data_out_rs2, rd_data;
  logic            write_en, issue_en, flush;
  logic            rs1_busy, rs2_busy;
  logic [ADDR:0]   pending_count;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_scoreboard #(.XLEN(XLEN), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .data_out_rs1(data_out_rs1),
    .rs2_addr(rs2_addr), .data_out_rs2(data_out_rs2),
    .write_en(write_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int sig);
    case (sig)
      S_RS1:   return data_out_rs1;
      S_RS2:   return data_out_rs2;
      S_B1:    return {31'd0, rs1_busy};
      S_B2:    return {31'd0, rs2_busy};
      default: return {26'd0, pending_count};
    endcase
  endfunction

  // Monitor: compare every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = exp_q.pop_front();
        a = actual(e.sig);
        n_checks++;
        if (a !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
        end
      end
    end
  end

  task automatic expect_out(int sig, logic [31:0] v, string n);
    exp_t e;
    e.sig = sig; e.exp = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0; rd_addr = '0; rd_data = '0;
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rs1_addr = 5; rs2_addr = 6;
    idle();
    expect_out(S_RS1, 32'h0, "reset_rs1_data");
    expect_out(S_CNT, 32'd0, "reset_count");
    expect_out(S_B2,  32'd0, "reset_rs2_busy");
    step();
    step();
    rst = 1'b0;

    // Preload x5 and mark x6 busy.
    write_en = 1; rd_addr = 5; rd_data = 32'hDEADBEEF;
    issue_en = 1; issue_rd = 6;
    step();
    idle();
    expect_out(S_RS1, 32'hDEADBEEF, "preload_x5");
    expect_out(S_B2,  32'd1, "preload_x6_busy");
    expect_out(S_CNT, 32'd1, "preload_count");
    step();
    // Asynchronous reset mid-cycle.
    #1 rst = 1'b1;
    expect_out(S_RS1, 32'h0, "async_rst_rs1_data");
    expect_out(S_CNT, 32'd0, "async_rst_count");
    expect_out(S_B2,  32'd0, "async_rst_rs2_busy");
    step();
    // Release and write on the very first edge.
    rst = 1'b0;
    write_en = 1; rd_addr = 7; rd_data = 32'h12345678;
    rs1_addr = 0; rs2_addr = 0;
    step();
    write_en = 1; rd_addr = 0; rd_data = 32'hFFFFFFFF;
    rs1_addr = 7; rs2_addr = 0;
    expect_out(S_RS1, 32'h12345678, "read_x7");
    expect_out(S_RS2, 32'h0, "x0_bypass_blocked");
    expect_out(S_CNT, 32'd0, "write_nonbusy_count");
    step();
    idle();
    expect_out(S_RS2, 32'h0, "x0_stored_zero");

    step();
    write_en = 1; rd_addr = 3; rd_data = 32'hA5A5A5A5;
    rs1_addr = 3; rs2_addr = 3;
    expect_out(S_RS1, 32'hA5A5A5A5, "bypass_rs1");
    expect_out(S_RS2, 32'hA5A5A5A5, "bypass_rs2");
    step();
    idle();
    rs2_addr = 0;
    expect_out(S_RS1, 32'hA5A5A5A5, "stored_x3");

    // Scoreboard basic.
    step();
    issue_en = 1; issue_rd = 9; rs1_addr = 9;
    expect_out(S_B1, 32'd0, "issue9_not_yet_busy");
    step();
    idle();
    expect_out(S_B1,  32'd1, "x9_busy");
    expect_out(S_CNT, 32'd1, "x9_count");
    step();
    write_en = 1; rd_addr = 9; rd_data = 32'h99;
    expect_out(S_B1,  32'd0, "wb9_masks_busy");
    expect_out(S_RS1, 32'h99, "wb9_bypass");
    expect_out(S_CNT, 32'd1, "wb9_count_before_edge");
    step();
    idle();
    issue_en = 1; issue_rd = 0;
    expect_out(S_B1,  32'd0, "x9_cleared");
    expect_out(S_CNT, 32'd0, "wb9_count_after_edge");
    step();
    idle();
    rs1_addr = 0;
    expect_out(S_CNT, 32'd0, "issue_x0_count");
    expect_out(S_B1,  32'd0, "issue_x0_busy");

    // Issue and writeback to the same register in one cycle.
    step();
    issue_en = 1; issue_rd = 4;
    write_en = 1; rd_addr = 4; rd_data = 32'h44;
    step();
    idle();
    rs1_addr = 4;
    expect_out(S_B1,  32'd1, "issue_beats_wb_busy");
    expect_out(S_RS1, 32'h44, "issue_wb_storage");
    expect_out(S_CNT, 32'd1, "issue_wb_count");
    step();
    write_en = 1; rd_addr = 4; rd_data = 32'h45;
    step();
    idle();
    expect_out(S_CNT, 32'd0, "x4_cleared_count");

    // Flush with a simultaneous issue and write.
    issue_en = 1; issue_rd = 10;
    step();
    issue_rd = 11;
    step();
    issue_rd = 12;
    expect_out(S_CNT, 32'd2, "pending_two");
    step();
    idle();
    flush = 1; issue_en = 1; issue_rd = 13;
    write_en = 1; rd_addr = 10; rd_data = 32'h55;
    expect_out(S_CNT, 32'd3, "pending_three");
    step();
    idle();
    rs1_addr = 13; rs2_addr = 10;
    expect_out(S_CNT, 32'd0, "flush_count");
    expect_out(S_B1,  32'd0, "flush_drops_issue13");
    expect_out(S_B2,  32'd0, "flush_x10_busy");
    expect_out(S_RS2, 32'h55, "flush_keeps_write");
    step();
    rs1_addr = 11; rs2_addr = 12;
    expect_out(S_B1, 32'd0, "flush_x11_busy");
    expect_out(S_B2, 32'd0, "flush_x12_busy");

    // Saturation.
    for (int i = 1; i < 32; i++) begin
      step();
      issue_en = 1; issue_rd = ADDR'(i);
    end
    step();
    idle();
    rs1_addr = 1; rs2_addr = 31;
    expect_out(S_CNT, 32'd31, "saturate_count");
    expect_out(S_B1,  32'd1, "saturate_x1_busy");
    expect_out(S_B2,  32'd1, "saturate_x31_busy");
    step();
    issue_en = 1; issue_rd = 1;
    write_en = 1; rd_addr = 0; rd_data = 32'hFFFFFFFF;
    step();
    idle();
    rs1_addr = 0;
    expect_out(S_CNT, 32'd31, "reissue_count");
    expect_out(S_RS1, 32'h0, "sat_x0_read");
    expect_out(S_B1,  32'd0, "sat_x0_busy");
    step();
    expect_out(S_CNT, 32'd31, "count_holds");
    step();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
